// File: rtl/mult_pkg.sv
// Shared state encoding and sizing helpers for the Booth multiplier operand sequencer.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_EMIT
    } seq_state_t;

    // Cycles from the multiplier loading its operands to its ready rising.
    function automatic int mult_latency(input int nb);
        return (nb + 1) / 2;
    endfunction

    function automatic int default_acc_w(input int nb);
        return 2 * nb + 4;
    endfunction

endpackage

// File: rtl/mult_operand_fifo.sv
// Small synchronous FIFO holding packed operand pairs; full/empty come from a registered count.
module mult_operand_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/mult_operand_sequencer.sv
// Feeds operand pairs to the Booth multiplier and accumulates its products per tagged group.
//   state    | meaning
//   ST_IDLE  | pop next pair from the FIFO when one is present
//   ST_START | pulse mul_start; multiplier loads at the end of this cycle
//   ST_WAIT  | wait for mul_ready, then accumulate the product
//   ST_EMIT  | hold the group result until out_ready
module mult_operand_sequencer
    import mult_pkg::*;
#(
    parameter int nb    = 10,
    parameter int DEPTH = 4,
    parameter int ACC_W = default_acc_w(nb),
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [nb-1:0]     in_a,
    input  logic [nb-1:0]     in_b,
    input  logic              in_last,
    output logic              mul_start,
    output logic [nb-1:0]     mul_a,
    output logic [nb-1:0]     mul_b,
    input  logic [2*nb-1:0]   mul_product,
    input  logic              mul_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count
);

    localparam int FW = 2 * nb + 1;

    seq_state_t       state;
    seq_state_t       state_next;
    logic [FW-1:0]    fifo_rd;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             capture;
    logic             release_out;
    logic             last_q;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign mul_start = (state == ST_START);

    mult_operand_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({in_a, in_b, in_last}),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign prod_ext = ACC_W'($signed(mul_product));
    assign sum_next = acc + prod_ext;
    assign cnt_next = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The multiplier has no reset, so mul_ready is only trusted in ST_WAIT.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_ready) begin
                    capture    = 1'b1;
                    state_next = last_q ? ST_EMIT : ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a     <= '0;
            mul_b     <= '0;
            last_q    <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            out_sum   <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            if (pop) begin
                {mul_a, mul_b, last_q} <= fifo_rd;
            end
            if (capture) begin
                if (last_q) begin
                    out_sum   <= sum_next;
                    out_count <= cnt_next;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= sum_next;
                    cnt <= cnt_next;
                end
            end
            if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench for mult_operand_sequencer with a behavioral Booth multiplier model per instance.
module tb_mult_operand_sequencer;

    localparam int LAT = 5;  // ceil(10/2) and ceil(9/2)

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // nb=10 instance
    logic        in_valid10, in_last10, out_ready10;
    logic [9:0]  in_a10, in_b10;
    logic        in_ready10, mul_start10, out_valid10;
    logic [9:0]  mul_a10, mul_b10;
    logic [19:0] mul_product10 = '0;
    logic        mul_ready10 = 1'b1;
    logic [23:0] out_sum10;
    logic [7:0]  out_count10;
    int          m_cnt10 = 0;
    int          starts10 = 0;

    // nb=9 instance
    logic        in_valid9, in_last9, out_ready9;
    logic [8:0]  in_a9, in_b9;
    logic        in_ready9, mul_start9, out_valid9;
    logic [8:0]  mul_a9, mul_b9;
    logic [17:0] mul_product9 = '0;
    logic        mul_ready9 = 1'b1;
    logic [21:0] out_sum9;
    logic [7:0]  out_count9;
    int          m_cnt9 = 0;

    mult_operand_sequencer #(.nb(10)) dut10 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid10), .in_ready(in_ready10),
        .in_a(in_a10), .in_b(in_b10), .in_last(in_last10),
        .mul_start(mul_start10), .mul_a(mul_a10), .mul_b(mul_b10),
        .mul_product(mul_product10), .mul_ready(mul_ready10),
        .out_valid(out_valid10), .out_ready(out_ready10),
        .out_sum(out_sum10), .out_count(out_count10)
    );

    mult_operand_sequencer #(.nb(9)) dut9 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid9), .in_ready(in_ready9),
        .in_a(in_a9), .in_b(in_b9), .in_last(in_last9),
        .mul_start(mul_start9), .mul_a(mul_a9), .mul_b(mul_b9),
        .mul_product(mul_product9), .mul_ready(mul_ready9),
        .out_valid(out_valid9), .out_ready(out_ready9),
        .out_sum(out_sum9), .out_count(out_count9)
    );

    function automatic longint sprod(input int a, input int b);
        return longint'(a) * longint'(b);
    endfunction

    // Multiplier models: load on start, ready rises LAT cycles into WAIT and holds.
    always @(posedge clk) begin
        if (mul_start10) begin
            m_cnt10       <= LAT;
            mul_ready10   <= 1'b0;
            mul_product10 <= 20'(sprod(int'($signed(mul_a10)), int'($signed(mul_b10))));
            starts10      <= starts10 + 1;
        end else if (m_cnt10 > 0) begin
            m_cnt10 <= m_cnt10 - 1;
            if (m_cnt10 == 1) mul_ready10 <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (mul_start9) begin
            m_cnt9       <= LAT;
            mul_ready9   <= 1'b0;
            mul_product9 <= 18'(sprod(int'($signed(mul_a9)), int'($signed(mul_b9))));
        end else if (m_cnt9 > 0) begin
            m_cnt9 <= m_cnt9 - 1;
            if (m_cnt9 == 1) mul_ready9 <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push10(input int a, input int b, input bit last);
        int n;
        in_a10 = 10'(a); in_b10 = 10'(b); in_last10 = last; in_valid10 = 1'b1;
        n = 0;
        while (!in_ready10 && n < 200) begin @(negedge clk); n++; end
        if (!in_ready10) check_eq("push10_timeout", 64'(in_ready10), 1);
        @(negedge clk);
        in_valid10 = 1'b0;
    endtask

    task automatic push9(input int a, input int b, input bit last);
        int n;
        in_a9 = 9'(a); in_b9 = 9'(b); in_last9 = last; in_valid9 = 1'b1;
        n = 0;
        while (!in_ready9 && n < 200) begin @(negedge clk); n++; end
        if (!in_ready9) check_eq("push9_timeout", 64'(in_ready9), 1);
        @(negedge clk);
        in_valid9 = 1'b0;
    endtask

    task automatic wait_valid10(output int k);
        k = 0;
        while (!out_valid10 && k < 200) begin @(negedge clk); k++; end
        if (!out_valid10) check_eq("valid10_timeout", 64'(out_valid10), 1);
    endtask

    task automatic consume10();
        out_ready10 = 1'b1;
        @(negedge clk);
        out_ready10 = 1'b0;
        check_eq("consume10_valid_drop", 64'(out_valid10), 0);
    endtask

    int exp_bp[6];
    int k;
    int s0;

    initial begin
        in_valid10 = 0; in_last10 = 0; out_ready10 = 0; in_a10 = '0; in_b10 = '0;
        in_valid9 = 0; in_last9 = 0; out_ready9 = 0; in_a9 = '0; in_b9 = '0;
        exp_bp = '{1, 6, -12, -30, 49, 72};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid10), 0);
        check_eq("rst_out_sum", 64'(out_sum10), 0);
        check_eq("rst_out_count", 64'(out_count10), 0);
        check_eq("rst_mul_start", 64'(mul_start10), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready10), 1);

        // Single pair with pop-to-valid latency
        push10(3, 5, 1'b1);
        check_eq("t1_no_early_valid", 64'(out_valid10), 0);
        k = 0;
        while (!out_valid10 && k < 40) begin
            @(negedge clk); k++;
            if (k == 1) begin
                check_eq("t1_start_pulse", 64'(mul_start10), 1);
                check_eq("t1_mul_a", 64'($signed(mul_a10)), 3);
            end
            if (k == 2) check_eq("t1_start_once", 64'(mul_start10), 0);
        end
        check_eq("t1_latency", k, 8);
        check_eq("t1_sum", 64'($signed(out_sum10)), 15);
        check_eq("t1_count", 64'(out_count10), 1);
        repeat (3) @(negedge clk);
        check_eq("t1_sum_held", 64'($signed(out_sum10)), 15);
        consume10();

        push10(-7, 6, 1'b1);
        wait_valid10(k);
        check_eq("neg_sum", 64'($signed(out_sum10)), -42);
        check_eq("neg_sum_raw", 64'(out_sum10), 64'h00FF_FFD6);
        consume10();

        push10(-512, -512, 1'b1);
        wait_valid10(k);
        check_eq("ext_sum", 64'($signed(out_sum10)), 262144);
        consume10();

        // Three-pair group
        s0 = starts10;
        push10(2, 3, 1'b0);
        push10(-4, 5, 1'b0);
        push10(10, 10, 1'b1);
        wait_valid10(k);
        check_eq("grp_products_before_valid", starts10 - s0, 3);
        check_eq("grp_sum", 64'($signed(out_sum10)), 86);
        check_eq("grp_count", 64'(out_count10), 3);
        consume10();

        // Backpressure: six single-pair groups with the consumer stalled
        push10(1, 1, 1'b1);
        push10(2, 3, 1'b1);
        push10(-3, 4, 1'b1);
        push10(5, -6, 1'b1);
        push10(7, 7, 1'b1);
        in_a10 = 10'(-8); in_b10 = 10'(-9); in_last10 = 1'b1; in_valid10 = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("bp_in_ready_low", 64'(in_ready10), 0);
        check_eq("bp_first_held", 64'($signed(out_sum10)), 1);
        fork
            begin
                int kk;
                out_ready10 = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    wait_valid10(kk);
                    check_eq($sformatf("bp_sum%0d", i), 64'($signed(out_sum10)), exp_bp[i]);
                    @(negedge clk);
                end
                out_ready10 = 1'b0;
            end
            begin
                int n;
                n = 0;
                while (!in_ready10 && n < 200) begin @(negedge clk); n++; end
                check_eq("bp_sixth_accepted", 64'(in_ready10), 1);
                @(negedge clk);
                in_valid10 = 1'b0;
            end
        join

        // Reset while the multiplier is busy
        push10(100, 100, 1'b1);
        k = 0;
        while (!mul_start10 && k < 40) begin @(negedge clk); k++; end
        check_eq("rw_saw_start", 64'(mul_start10), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rw_out_valid", 64'(out_valid10), 0);
        check_eq("rw_out_sum", 64'(out_sum10), 0);
        check_eq("rw_out_count", 64'(out_count10), 0);
        check_eq("rw_mul_a", 64'(mul_a10), 0);
        check_eq("rw_mul_b", 64'(mul_b10), 0);
        check_eq("rw_in_ready", 64'(in_ready10), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rw_no_stale_valid", 64'(out_valid10), 0);
        push10(1, 1, 1'b1);
        wait_valid10(k);
        check_eq("rw_sum", 64'($signed(out_sum10)), 1);
        check_eq("rw_count", 64'(out_count10), 1);
        consume10();

        // nb=9 instance
        push9(255, -256, 1'b1);
        k = 0;
        while (!out_valid9 && k < 40) begin @(negedge clk); k++; end
        check_eq("nb9_latency", k, 8);
        check_eq("nb9_sum", 64'($signed(out_sum9)), -65280);
        check_eq("nb9_count", 64'(out_count9), 1);
        out_ready9 = 1'b1;
        @(negedge clk);
        out_ready9 = 1'b0;
        check_eq("nb9_valid_drop", 64'(out_valid9), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
